fp_addsub_sched: RTL and testbench

FP_ADDSUB_SCHED -- requirements
Module: fp_addsub_sched

---
 rtl/fp_addsub_sched.sv | 187 ++++++++++++++++++
 tb/tb_fp_addsub_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one fixed-latency FP add/sub datapath between two
// requesters, with credit-based flow control into per-channel response FIFOs.
module fp_addsub_sched #(
   parameter int LAT   = 3,
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_op,
   output logic        dp_start,
   output logic [31:0] dp_a,
   output logic [31:0] dp_b,
   output logic        dp_op,
   input  logic [31:0] dp_result,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,
   output logic        busy
);

   localparam logic [2:0] DEPTH_C = 3'(DEPTH);
   localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

   // FIFO pointers wrap at DEPTH-1, storage is always sized for the maximum depth
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      if (p == LAST_C) begin
         ptr_inc = 2'd0;
      end else begin
         ptr_inc = p + 2'd1;
      end
   endfunction

   logic                   run_q, run_d;
   logic                   ptr_q, ptr_d;
   logic [1:0][2:0]        credit_q, credit_d;
   logic [1:0][2:0]        cnt_q, cnt_d;
   logic [1:0][1:0]        wr_q, wr_d;
   logic [1:0][1:0]        rd_q, rd_d;
   logic [1:0][3:0][31:0]  mem_q, mem_d;
   logic [LAT:0]           tag_vld_q, tag_vld_d;
   logic [LAT:0]           tag_ch_q, tag_ch_d;
   logic                   dp_start_q, dp_start_d;
   logic [31:0]            dp_a_q, dp_a_d;
   logic [31:0]            dp_b_q, dp_b_d;
   logic                   dp_op_q, dp_op_d;

   logic [1:0]             elig_s;
   logic [1:0]             gnt_s;
   logic [1:0]             wr_s;
   logic [1:0]             pop_s;
   logic [1:0]             rsp_ready_s;

   // Arbitration, issue register and tag pipeline next-state
   always_comb begin
      run_d     = 1'b1;
      elig_s[0] = run_q & req0_valid & (credit_q[0] != 3'd0);
      elig_s[1] = run_q & req1_valid & (credit_q[1] != 3'd0);
      gnt_s[0]  = elig_s[0] & (~elig_s[1] | ~ptr_q);
      gnt_s[1]  = elig_s[1] & (~elig_s[0] | ptr_q);

      if (gnt_s[0]) begin
         ptr_d = 1'b1;
      end else if (gnt_s[1]) begin
         ptr_d = 1'b0;
      end else begin
         ptr_d = ptr_q;
      end

      dp_start_d = gnt_s[0] | gnt_s[1];
      if (gnt_s[0]) begin
         dp_a_d  = req0_a;
         dp_b_d  = req0_b;
         dp_op_d = req0_op;
      end else if (gnt_s[1]) begin
         dp_a_d  = req1_a;
         dp_b_d  = req1_b;
         dp_op_d = req1_op;
      end else begin
         dp_a_d  = 32'h0000_0000;
         dp_b_d  = 32'h0000_0000;
         dp_op_d = 1'b0;
      end

      // Stage LAT lines up with the cycle in which dp_result is valid
      tag_vld_d = {tag_vld_q[LAT-1:0], dp_start_d};
      tag_ch_d  = {tag_ch_q[LAT-1:0], gnt_s[1]};
   end

   // Response FIFO and credit bookkeeping per channel
   always_comb begin
      rsp_ready_s = {rsp1_ready, rsp0_ready};
      mem_d       = mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      credit_d    = credit_q;
      wr_s        = 2'b00;
      pop_s       = 2'b00;
      for (int n = 0; n < 2; n++) begin
         wr_s[n[0]]  = tag_vld_q[LAT] & (tag_ch_q[LAT] == n[0]);
         pop_s[n[0]] = (cnt_q[n[0]] != 3'd0) & rsp_ready_s[n[0]];
         if (wr_s[n[0]]) begin
            mem_d[n[0]][wr_q[n[0]]] = dp_result;
            wr_d[n[0]]              = ptr_inc(wr_q[n[0]]);
         end else begin
            wr_d[n[0]] = wr_q[n[0]];
         end
         if (pop_s[n[0]]) begin
            rd_d[n[0]] = ptr_inc(rd_q[n[0]]);
         end else begin
            rd_d[n[0]] = rd_q[n[0]];
         end
         cnt_d[n[0]]    = cnt_q[n[0]] + {2'b00, wr_s[n[0]]} - {2'b00, pop_s[n[0]]};
         credit_d[n[0]] = credit_q[n[0]] - {2'b00, gnt_s[n[0]]} + {2'b00, pop_s[n[0]]};
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         ptr_q      <= 1'b0;
         credit_q   <= {DEPTH_C, DEPTH_C};
         cnt_q      <= {3'd0, 3'd0};
         wr_q       <= {2'd0, 2'd0};
         rd_q       <= {2'd0, 2'd0};
         mem_q      <= '0;
         tag_vld_q  <= {(LAT + 1){1'b0}};
         tag_ch_q   <= {(LAT + 1){1'b0}};
         dp_start_q <= 1'b0;
         dp_a_q     <= 32'h0000_0000;
         dp_b_q     <= 32'h0000_0000;
         dp_op_q    <= 1'b0;
      end else begin
         run_q      <= run_d;
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         mem_q      <= mem_d;
         tag_vld_q  <= tag_vld_d;
         tag_ch_q   <= tag_ch_d;
         dp_start_q <= dp_start_d;
         dp_a_q     <= dp_a_d;
         dp_b_q     <= dp_b_d;
         dp_op_q    <= dp_op_d;
      end
   end

   // Response data is forced to zero whenever the FIFO is empty
   always_comb begin
      if (cnt_q[0] != 3'd0) begin
         rsp0_data = mem_q[0][rd_q[0]];
      end else begin
         rsp0_data = 32'h0000_0000;
      end
      if (cnt_q[1] != 3'd0) begin
         rsp1_data = mem_q[1][rd_q[1]];
      end else begin
         rsp1_data = 32'h0000_0000;
      end
   end

   assign req0_ready = gnt_s[0];
   assign req1_ready = gnt_s[1];
   assign dp_start   = dp_start_q;
   assign dp_a       = dp_a_q;
   assign dp_b       = dp_b_q;
   assign dp_op      = dp_op_q;
   assign rsp0_valid = (cnt_q[0] != 3'd0);
   assign rsp1_valid = (cnt_q[1] != 3'd0);
   assign busy       = (|tag_vld_q) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a behavioural fixed-latency datapath model
// answers dp_start, and every response, grant and flag is checked against hand values.
module tb_fp_addsub_sched;

   localparam int LAT   = 3;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req1_a, req1_b;
   logic        dp_start, dp_op;
   logic [31:0] dp_a, dp_b, dp_result;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic        busy;

   fp_addsub_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_result(dp_result),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errs   = 0;

   // cycle snapshots taken at the falling edge
   logic        s_r0rdy, s_r1rdy, s_dps, s_dpop, s_rv0, s_rv1, s_busy;
   logic [31:0] s_dpa, s_dpb, s_rd0, s_rd1;
   int          g0, g1, nrsp;
   int          glog[$];
   int          gcyc[$];
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   // stand-in datapath: two real FP vectors, otherwise a cheap reversible mix
   function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) begin
         dp_model = 32'h4040_0000;
      end else if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op) begin
         dp_model = 32'h4000_0000;
      end else begin
         dp_model = a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
      end
   endfunction

   logic        sch_v[64];
   logic [31:0] sch_d[64];
   logic [5:0]  slot_w, slot_r;

   always @(negedge clk) begin
      slot_w = 6'(cyc + LAT);
      slot_r = 6'(cyc);
      if (dp_start) begin
         sch_v[slot_w] = 1'b1;
         sch_d[slot_w] = dp_model(dp_a, dp_b, dp_op);
      end
      if (sch_v[slot_r]) begin
         dp_result     = sch_d[slot_r];
         sch_v[slot_r] = 1'b0;
      end else begin
         dp_result = 32'hBAD0_0000 | 32'(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc_step();
      @(negedge clk);
      s_r0rdy = req0_ready; s_r1rdy = req1_ready;
      s_dps = dp_start; s_dpa = dp_a; s_dpb = dp_b; s_dpop = dp_op;
      s_rv0 = rsp0_valid; s_rd0 = rsp0_data; s_rv1 = rsp1_valid; s_rd1 = rsp1_data;
      s_busy = busy;
      if (req0_valid && req0_ready) begin g0++; glog.push_back(0); gcyc.push_back(cyc); end
      if (req1_valid && req1_ready) begin g1++; glog.push_back(1); gcyc.push_back(cyc); end
      if (rsp0_valid && rsp0_ready) q0.push_back(rsp0_data);
      if (rsp1_valid && rsp1_ready) q1.push_back(rsp1_data);
      if (rsp0_valid || rsp1_valid) nrsp++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic [31:0] b0, input logic [31:0] b1);
      for (int i = 0; i < n; i++) begin
         req0_a = b0 + 32'(g0);
         req1_a = b1 + 32'(g1);
         cyc_step();
      end
   endtask

   task automatic clear_logs();
      g0 = 0; g1 = 0; nrsp = 0;
      glog.delete(); gcyc.delete(); q0.delete(); q1.delete();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) sch_v[i] = 1'b0;
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h0; req0_b = 32'h0; req0_op = 1'b0;
      req1_valid = 1'b0; req1_a = 32'h0; req1_b = 32'h0; req1_op = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      clear_logs();

      // reset: every output low even with a request pending
      cyc_step();
      cyc_step();
      check("rst_req0_ready", 32'(s_r0rdy), 32'd0);
      check("rst_dp_start", 32'(s_dps), 32'd0);
      check("rst_rsp0_valid", 32'(s_rv0), 32'd0);
      check("rst_rsp_data", s_rd0 | s_rd1, 32'h0);
      check("rst_busy", 32'(s_busy), 32'd0);

      req0_valid = 1'b0;
      rst_n = 1'b1;
      cyc_step();
      cyc_step();

      // single add on channel 0
      req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_op = 1'b0;
      cyc_step();
      check("t1_handshake", 32'(s_r0rdy), 32'd1);
      req0_valid = 1'b0;
      cyc_step();
      check("t1_dp_start", 32'(s_dps), 32'd1);
      check("t1_dp_a", s_dpa, 32'h3F80_0000);
      check("t1_dp_b", s_dpb, 32'h4000_0000);
      check("t1_dp_op", 32'(s_dpop), 32'd0);
      check("t1_busy", 32'(s_busy), 32'd1);
      cyc_step();
      check("t1_idle_dp_start", 32'(s_dps), 32'd0);
      check("t1_idle_dp_a", s_dpa, 32'h0);
      cyc_step();
      cyc_step();
      check("t1_rsp_early", 32'(s_rv0), 32'd0);
      cyc_step();
      check("t1_rsp0_valid", 32'(s_rv0), 32'd1);
      check("t1_rsp0_data", s_rd0, 32'h4040_0000);
      check("t1_rsp1_valid", 32'(s_rv1), 32'd0);
      cyc_step();
      check("t1_rsp0_drained", 32'(s_rv0), 32'd0);
      check("t1_busy_done", 32'(s_busy), 32'd0);

      // subtract on channel 1
      req1_valid = 1'b1; req1_a = 32'h4040_0000; req1_b = 32'h3F80_0000; req1_op = 1'b1;
      cyc_step();
      check("t2_handshake", 32'(s_r1rdy), 32'd1);
      req1_valid = 1'b0;
      cyc_step();
      check("t2_dp_op", 32'(s_dpop), 32'd1);
      check("t2_dp_a", s_dpa, 32'h4040_0000);
      for (int i = 0; i < 3; i++) cyc_step();
      cyc_step();
      check("t2_rsp1_valid", 32'(s_rv1), 32'd1);
      check("t2_rsp1_data", s_rd1, 32'h4000_0000);
      check("t2_rsp0_valid", 32'(s_rv0), 32'd0);
      cyc_step();

      // contention: both channels valid, results read immediately
      clear_logs();
      req0_b = 32'h0; req1_b = 32'h0; req0_op = 1'b0; req1_op = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      run(12, 32'h100, 32'h200);
      req0_valid = 1'b0; req1_valid = 1'b0;
      run(10, 32'h100, 32'h200);
      check("t3_grants_ch0", 32'(g0), 32'd4);
      check("t3_grants_ch1", 32'(g1), 32'd4);
      check("t3_grant_count", 32'(glog.size()), 32'd8);
      if (glog.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("t3_alternate", 32'(glog[i]), 32'(i % 2));
         check("t3_back_to_back", 32'(gcyc[3] - gcyc[0]), 32'd3);
      end
      check("t3_rsp0_count", 32'(q0.size()), 32'd4);
      check("t3_rsp1_count", 32'(q1.size()), 32'd4);
      for (int i = 0; i < q0.size(); i++) check("t3_rsp0_order", q0[i], 32'h100 + 32'(i));
      for (int i = 0; i < q1.size(); i++) check("t3_rsp1_order", q1[i], 32'h200 + 32'(i));

      // backpressure on channel 0 while channel 1 keeps issuing
      clear_logs();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      run(16, 32'h300, 32'h400);
      check("t4_ch0_stalled", 32'(g0), 32'd2);
      check("t4_ch1_continues", 32'(g1 >= 4), 32'd1);
      rsp0_ready = 1'b1;
      run(1, 32'h300, 32'h400);
      check("t4_pop_valid", 32'(s_rv0), 32'd1);
      check("t4_pop_data", s_rd0, 32'h300);
      check("t4_no_same_cycle_grant", 32'(s_r0rdy), 32'd0);
      rsp0_ready = 1'b0;
      run(1, 32'h300, 32'h400);
      check("t4_next_cycle_grant", 32'(s_r0rdy), 32'd1);
      run(10, 32'h300, 32'h400);
      check("t4_one_extra_grant", 32'(g0), 32'd3);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
      run(12, 32'h300, 32'h400);
      check("t4_rsp0_count", 32'(q0.size()), 32'd3);
      for (int i = 0; i < q0.size(); i++) check("t4_rsp0_order", q0[i], 32'h300 + 32'(i));
      check("t4_rsp1_count", 32'(q1.size()), 32'(g1));
      check("t4_busy_done", 32'(s_busy), 32'd0);

      // reset with two operations in flight
      clear_logs();
      req0_valid = 1'b1;
      run(2, 32'h500, 32'h600);
      check("t5_two_grants", 32'(g0), 32'd2);
      req0_valid = 1'b0;
      cyc_step();
      check("t5_busy_before", 32'(s_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_busy_in_reset", 32'(busy), 32'd0);
      check("t5_rsp_in_reset", 32'(rsp0_valid | rsp1_valid), 32'd0);
      cyc_step();
      rst_n = 1'b1;
      nrsp = 0;
      run(12, 32'h500, 32'h600);
      check("t5_no_late_rsp", 32'(nrsp), 32'd0);
      check("t5_busy_after", 32'(s_busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
